// File: rtl/render_frame_scheduler_if.sv
// Column-job handshake between the frame scheduler (master) and the ray-cast engine (slave).
interface render_frame_scheduler_if #(
  parameter int COL_W = 9
);
  logic             col_valid;
  logic [COL_W-1:0] col_idx;
  logic             col_ready;
  logic             col_done;

  modport master (output col_valid, col_idx, input col_ready, col_done);
  modport slave  (input col_valid, col_idx, output col_ready, col_done);
endinterface

// File: rtl/render_frame_scheduler.sv
// Per-frame column job sequencer with double-buffer swap at vblank.
module render_frame_scheduler #(
  parameter int NUM_COLS = 320,
  parameter int COL_W    = 9,
  parameter int V_ACTIVE = 480,
  parameter int DROP_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [9:0]                h_count,
  input  logic [9:0]                v_count,
  input  logic                      enable,
  render_frame_scheduler_if.master  col,
  output logic                      front_buf,
  output logic                      render_buf,
  output logic                      frame_swap,
  output logic                      overrun,
  output logic [DROP_W-1:0]         drop_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, READY} state_t;

  localparam logic [COL_W-1:0] LAST_IDX = COL_W'(NUM_COLS - 1);
  localparam logic [COL_W:0]   ALL_COLS = (COL_W + 1)'(NUM_COLS);

  state_t         state;
  logic [COL_W:0] done_cnt;
  logic [COL_W:0] xfer_total;
  logic           tick;
  logic           xfer;
  logic           done_inc;

  assign tick       = (v_count == 10'(V_ACTIVE)) && (h_count == 10'd0);
  assign xfer       = (state == ISSUE) && col.col_valid && col.col_ready;
  assign render_buf = ~front_buf;

  // Jobs handed to the engine so far, including one accepted this cycle;
  // done pulses beyond this bound belong to no outstanding job.
  always_comb begin
    xfer_total = '0;
    case (state)
      ISSUE:   xfer_total = {1'b0, col.col_idx} + (COL_W + 1)'(xfer);
      WAIT:    xfer_total = ALL_COLS;
      default: xfer_total = '0;
    endcase
  end

  assign done_inc = col.col_done && (done_cnt < xfer_total);

  // NOTE: rst is sampled only at the clock edge, so it sits inside the
  // clocked branch rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      col.col_valid <= 1'b0;
      col.col_idx   <= '0;
      done_cnt      <= '0;
      front_buf     <= 1'b0;
      frame_swap    <= 1'b0;
      overrun       <= 1'b0;
      drop_count    <= '0;
    end else begin
      // NOTE: non-blocking throughout; the later done_cnt clear on frame
      // start deliberately overrides the increment above it.
      frame_swap <= 1'b0;
      overrun    <= 1'b0;
      if (done_inc) done_cnt <= done_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (tick && enable) begin
            state         <= ISSUE;
            col.col_valid <= 1'b1;
            col.col_idx   <= '0;
            done_cnt      <= '0;
          end
        end
        ISSUE: begin
          if (xfer) begin
            if (col.col_idx == LAST_IDX) begin
              state         <= WAIT;
              col.col_valid <= 1'b0;
            end else begin
              col.col_idx <= col.col_idx + 1'b1;
            end
          end
        end
        WAIT: begin
          // A tick here is an overrun; the state holds until the next cycle.
          if (!tick && done_cnt == ALL_COLS) state <= READY;
        end
        READY: begin
          if (tick) begin
            front_buf  <= ~front_buf;
            frame_swap <= 1'b1;
            if (enable) begin
              state         <= ISSUE;
              col.col_valid <= 1'b1;
              col.col_idx   <= '0;
              done_cnt      <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (tick && (state == ISSUE || state == WAIT)) begin
        overrun <= 1'b1;
        if (drop_count != {DROP_W{1'b1}}) drop_count <= drop_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_render_frame_scheduler.sv
// Directed bench: table-driven tick decode plus multi-frame sequences against an engine model.
module tb_render_frame_scheduler;
  localparam int NUM_COLS = 320;
  localparam int COL_W    = 9;
  localparam int DROP_W   = 8;
  localparam int BOUND    = 5000;

  logic              clk = 1'b0;
  logic              rst;
  logic [9:0]        h_count, v_count;
  logic              enable;
  logic              front_buf, render_buf, frame_swap, overrun;
  logic [DROP_W-1:0] drop_count;

  always #5 clk = ~clk;

  render_frame_scheduler_if #(.COL_W(COL_W)) col_if ();

  render_frame_scheduler #(
    .NUM_COLS(NUM_COLS), .COL_W(COL_W), .V_ACTIVE(480), .DROP_W(DROP_W)
  ) dut (
    .clk(clk), .rst(rst), .h_count(h_count), .v_count(v_count), .enable(enable),
    .col(col_if), .front_buf(front_buf), .render_buf(render_buf),
    .frame_swap(frame_swap), .overrun(overrun), .drop_count(drop_count)
  );

  // Controls written only by the main sequence.
  int ready_mode  = 0;  // 0: always ready, 1: 1,0,0,1 pattern, 2: never ready
  int hold_limit  = 0;  // cumulative number of real dones to withhold
  int rel_limit   = 0;  // cumulative number of withheld dones to release
  int extra_limit = 0;  // cumulative number of spurious dones to inject

  // Engine model state, written only by the engine process.
  int               cyc_n = 0, xfers = 0, done_out = 0;
  int               held_n = 0, rel_n = 0, extra_n = 0;
  int               idx_err = 0, stall_err = 0, rphase = 0;
  int               due[$];
  logic [COL_W-1:0] exp_idx = '0, stall_idx = '0;
  logic             prev_valid = 1'b0, prev_stall = 1'b0;

  // Engine: inputs change on the falling edge, the DUT samples them on the next rising edge.
  initial begin
    logic rdy, dn;
    col_if.col_ready = 1'b0;
    col_if.col_done  = 1'b0;
    forever begin
      @(negedge clk);
      cyc_n++;
      case (ready_mode)
        0:       rdy = 1'b1;
        1:       rdy = (rphase % 4 == 0) || (rphase % 4 == 3);
        default: rdy = 1'b0;
      endcase
      rphase++;
      dn = 1'b0;
      if (due.size() > 0 && due[0] <= cyc_n) begin
        void'(due.pop_front());
        if (held_n < hold_limit) held_n++;
        else begin dn = 1'b1; done_out++; end
      end else if (rel_n < rel_limit && rel_n < held_n) begin
        rel_n++; dn = 1'b1; done_out++;
      end else if (extra_n < extra_limit) begin
        extra_n++; dn = 1'b1;
      end
      col_if.col_ready = rdy;
      col_if.col_done  = dn;

      if (col_if.col_valid && !prev_valid) exp_idx = '0;
      if (col_if.col_valid && prev_stall && col_if.col_idx != stall_idx) stall_err++;
      if (col_if.col_valid && rdy) begin
        if (col_if.col_idx != exp_idx) idx_err++;
        exp_idx++;
        xfers++;
        due.push_back(cyc_n + 2);
        prev_stall = 1'b0;
      end else begin
        prev_stall = col_if.col_valid;
        stall_idx  = col_if.col_idx;
      end
      prev_valid = col_if.col_valid;
    end
  end

  int total = 0, bad = 0;
  int base_x = 0, base_d = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_tick();
    v_count = 10'd480; h_count = 10'd0;
    @(negedge clk);
    v_count = 10'd0; h_count = 10'd1;
  endtask

  task automatic restart_base();
    base_x = xfers;
    base_d = done_out;
  endtask

  task automatic wait_xfers(input string name, input int n);
    int k = 0;
    while (xfers - base_x < n && k < BOUND) begin @(negedge clk); k++; end
    check(name, xfers - base_x, n);
  endtask

  task automatic wait_done(input string name, input int n);
    int k = 0;
    while (done_out - base_d < n && k < BOUND) begin @(negedge clk); k++; end
    check(name, done_out - base_d, n);
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    logic [9:0] h;
    logic [9:0] v;
    logic       en;
    logic       exp_valid;
  } vec_t;

  vec_t tab[6];

  initial begin
    tab[0] = '{h: 10'd0, v: 10'd0,   en: 1'b1, exp_valid: 1'b0};
    tab[1] = '{h: 10'd0, v: 10'd480, en: 1'b0, exp_valid: 1'b0};
    tab[2] = '{h: 10'd1, v: 10'd480, en: 1'b1, exp_valid: 1'b0};
    tab[3] = '{h: 10'd0, v: 10'd479, en: 1'b1, exp_valid: 1'b0};
    tab[4] = '{h: 10'd0, v: 10'd481, en: 1'b1, exp_valid: 1'b0};
    tab[5] = '{h: 10'd0, v: 10'd480, en: 1'b1, exp_valid: 1'b1};

    rst = 1'b0; enable = 1'b0; h_count = 10'd1; v_count = 10'd0;
    repeat (2) @(negedge clk);
    check("rst_valid", col_if.col_valid, 0);
    check("rst_idx", col_if.col_idx, 0);
    check("rst_front", front_buf, 0);
    check("rst_render", render_buf, 1);
    check("rst_swap", frame_swap, 0);
    check("rst_overrun", overrun, 0);
    check("rst_drop", drop_count, 0);
    rst = 1'b1;
    @(negedge clk);

    // Tick decode from IDLE; the final entry starts frame 1.
    restart_base();
    for (int i = 0; i < 6; i++) begin
      h_count = tab[i].h; v_count = tab[i].v; enable = tab[i].en;
      @(negedge clk);
      h_count = 10'd1; v_count = 10'd0;
      check($sformatf("tab%0d_valid", i), col_if.col_valid, tab[i].exp_valid);
      check($sformatf("tab%0d_idx", i), col_if.col_idx, 0);
      check($sformatf("tab%0d_overrun", i), overrun, 0);
    end

    // Frame 1: full-rate issue, one index per cycle.
    repeat (319) @(negedge clk);
    check("f1_idx_last", col_if.col_idx, 319);
    check("f1_valid_last", col_if.col_valid, 1);
    @(negedge clk);
    check("f1_valid_wait", col_if.col_valid, 0);
    wait_xfers("f1_xfers", NUM_COLS);
    wait_done("f1_dones", NUM_COLS);
    check("f1_idx_err", idx_err, 0);
    check("f1_front_pre", front_buf, 0);
    ready_mode = 1;
    restart_base();
    do_tick();
    check("f1_swap", frame_swap, 1);
    check("f1_front", front_buf, 1);
    check("f1_render", render_buf, 0);
    check("f1_restart_valid", col_if.col_valid, 1);
    check("f1_restart_idx", col_if.col_idx, 0);
    check("f1_no_overrun", overrun, 0);
    @(negedge clk);
    check("f1_swap_pulse", frame_swap, 0);

    // Frame 2: backpressure.
    wait_xfers("f2_xfers", NUM_COLS);
    wait_done("f2_dones", NUM_COLS);
    check("f2_xfers_exact", xfers - base_x, NUM_COLS);
    check("f2_idx_err", idx_err, 0);
    check("f2_stall_err", stall_err, 0);
    ready_mode = 0;
    hold_limit = 10;
    restart_base();
    do_tick();
    check("f2_swap", frame_swap, 1);
    check("f2_front", front_buf, 0);

    // Frame 3: ten dones withheld across two ticks.
    wait_xfers("f3_xfers", NUM_COLS);
    wait_done("f3_dones_partial", NUM_COLS - 10);
    do_tick();
    check("f3_overrun1", overrun, 1);
    check("f3_noswap1", frame_swap, 0);
    check("f3_drop1", drop_count, 1);
    @(negedge clk);
    check("f3_overrun_pulse", overrun, 0);
    do_tick();
    check("f3_overrun2", overrun, 1);
    check("f3_drop2", drop_count, 2);
    check("f3_front_held", front_buf, 0);
    rel_limit = 10;
    wait_done("f3_dones", NUM_COLS);
    ready_mode = 2;
    hold_limit = 15;
    restart_base();
    do_tick();
    check("f3_swap", frame_swap, 1);
    check("f3_front", front_buf, 1);

    // Frame 4: spurious dones before any transfer, five real dones held, saturation.
    extra_limit = 5;
    repeat (8) @(negedge clk);
    check("f4_stall_valid", col_if.col_valid, 1);
    check("f4_stall_idx", col_if.col_idx, 0);
    ready_mode = 0;
    wait_xfers("f4_xfers", NUM_COLS);
    wait_done("f4_dones_partial", NUM_COLS - 5);
    do_tick();
    check("f4_spurious_overrun", overrun, 1);
    check("f4_spurious_noswap", frame_swap, 0);
    check("f4_drop3", drop_count, 3);
    repeat (251) do_tick();
    check("f4_drop254", drop_count, 254);
    repeat (48) do_tick();
    check("f4_drop_sat", drop_count, 255);
    check("f4_front_held", front_buf, 1);
    rel_limit = 15;
    wait_done("f4_dones", NUM_COLS);
    restart_base();
    do_tick();
    check("f4_swap", frame_swap, 1);
    check("f4_front", front_buf, 0);
    check("f4_drop_kept", drop_count, 255);

    // Frame 5: enable cleared while waiting.
    wait_xfers("f5_xfers", NUM_COLS);
    enable = 1'b0;
    wait_done("f5_dones", NUM_COLS);
    do_tick();
    check("f5_swap", frame_swap, 1);
    check("f5_front", front_buf, 1);
    check("f5_idle_valid", col_if.col_valid, 0);
    repeat (4) @(negedge clk);
    do_tick();
    check("f5_idle_tick_valid", col_if.col_valid, 0);
    check("f5_idle_tick_swap", frame_swap, 0);
    check("f5_idle_tick_overrun", overrun, 0);
    enable = 1'b1;
    restart_base();
    do_tick();
    check("f5_reissue_valid", col_if.col_valid, 1);
    check("f5_reissue_idx", col_if.col_idx, 0);
    check("f5_reissue_noswap", frame_swap, 0);
    check("f5_reissue_front", front_buf, 1);

    // Frame 6: reset in the middle of issue.
    begin
      int k = 0;
      while (col_if.col_idx != 9'd150 && k < BOUND) begin @(negedge clk); k++; end
      check("f6_reach_150", col_if.col_idx, 150);
    end
    rst = 1'b0;
    @(negedge clk);
    check("f6_rst_valid", col_if.col_valid, 0);
    check("f6_rst_idx", col_if.col_idx, 0);
    check("f6_rst_front", front_buf, 0);
    check("f6_rst_drop", drop_count, 0);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("f6_quiet_valid", col_if.col_valid, 0);
    check("f6_quiet_swap", frame_swap, 0);
    restart_base();
    do_tick();
    check("f6_start_valid", col_if.col_valid, 1);
    check("f6_start_swap", frame_swap, 0);
    wait_xfers("f6_xfers", NUM_COLS);
    wait_done("f6_dones", NUM_COLS);
    do_tick();
    check("f6_swap", frame_swap, 1);
    check("f6_front", front_buf, 1);
    check("f6_no_overrun", overrun, 0);
    check("final_idx_err", idx_err, 0);
    check("final_stall_err", stall_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
